// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encodings, access
// op encodings and the wait-counter width.
package mem_responder_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned LAT_W   = 4;   // holds LATENCY values 0..15

    localparam logic [STATE_W-1:0] ST_IDLE = 4'd0;
    localparam logic [STATE_W-1:0] ST_WAIT = 4'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 4'd2;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word storage for the memory responder.
// Ports:
//   clk    - clock; writes happen on the rising edge
//   we     - write enable
//   waddr  - word index written when we=1
//   wdata  - word written
//   raddr  - word index for the combinational read port
//   rdata_c- combinational read data at raddr
module mem_responder_mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory serving multi-cycle processor requests with a
// programmable number of wait states and a one-cycle MemReady pulse.
// Ports:
//   clk       - clock, all state updates on rising edge
//   rst       - synchronous reset, active-low
//   MemRead   - read request, held until MemReady
//   MemWrite  - write request, held until MemReady (wins over MemRead)
//   Adr       - byte address
//   WriteData - store data
//   ReadData  - registered read data, valid with MemReady, holds otherwise
//   MemReady  - one-cycle completion pulse
//   Busy      - accepted request waiting to complete
//   AdrErr    - completed request was misaligned or out of range
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Adr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemReady,
    output logic              Busy,
    output logic              AdrErr
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [STATE_W-1:0] state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               op_q, op_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  rdata_d;
    logic               ready_d, busy_d, adr_err_d;

    logic               illegal_c;
    logic               we_c;
    logic [IDX_W-1:0]   rd_idx_c;
    logic [DATA_W-1:0]  mem_rdata_c;

    // Illegal: not word aligned, or word index beyond the array (DEPTH is a
    // power of two, so any set bit above the index field is out of range).
    assign illegal_c = (Adr[1:0] != 2'b00) || (|Adr[ADDR_W-1:IDX_W+2]);

    mem_responder_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .we      (we_c),
        .waddr   (idx_q),
        .wdata   (wdata_q),
        .raddr   (rd_idx_c),
        .rdata_c (mem_rdata_c)
    );

    // State, latches and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            op_q     <= OP_RD;
            err_q    <= 1'b0;
            ReadData <= '0;
            MemReady <= 1'b0;
            Busy     <= 1'b0;
            AdrErr   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            op_q     <= op_d;
            err_q    <= err_d;
            ReadData <= rdata_d;
            MemReady <= ready_d;
            Busy     <= busy_d;
            AdrErr   <= adr_err_d;
        end
    end

    // Next-state and next-output logic; outputs describe the state entered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        op_d      = op_q;
        err_d     = err_q;
        rdata_d   = ReadData;
        ready_d   = 1'b0;
        busy_d    = 1'b0;
        adr_err_d = 1'b0;
        we_c      = 1'b0;
        rd_idx_c  = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (MemRead || MemWrite) begin
                    idx_d    = Adr[IDX_W+1:2];
                    wdata_d  = WriteData;
                    op_d     = MemWrite ? OP_WR : OP_RD;
                    err_d    = illegal_c;
                    // Zero latency reads straight from the incoming address.
                    rd_idx_c = Adr[IDX_W+1:2];
                    if (LATENCY == 0) begin
                        state_d   = ST_DONE;
                        ready_d   = 1'b1;
                        adr_err_d = illegal_c;
                        if (illegal_c) begin
                            rdata_d = '0;
                        end else if (!MemWrite) begin
                            rdata_d = mem_rdata_c;
                        end
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_W'(LATENCY);
                        busy_d  = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) begin
                    state_d   = ST_DONE;
                    ready_d   = 1'b1;
                    adr_err_d = err_q;
                    if (err_q) begin
                        rdata_d = '0;
                    end else if (op_q == OP_RD) begin
                        rdata_d = mem_rdata_c;
                    end
                end else begin
                    busy_d = 1'b1;
                end
            end

            ST_DONE: begin
                // The write lands on the edge leaving DONE.
                state_d = ST_IDLE;
                cnt_d   = '0;
                we_c    = (op_q == OP_WR) && !err_q;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY 2 and 0) checked against a
// word-array reference model with directed and randomized transactions.
module tb_mem_responder;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           mem_read  [2];
    logic           mem_write [2];
    logic [AW-1:0]  adr       [2];
    logic [DW-1:0]  wdata     [2];
    logic [DW-1:0]  rdata     [2];
    logic           ready     [2];
    logic           busy      [2];
    logic           aerr      [2];

    logic [DW-1:0]  model     [2][DEPTH];
    logic [DW-1:0]  last_rd   [2];

    int checks = 0;
    int errors = 0;

    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
        .Adr(adr[0]), .WriteData(wdata[0]), .ReadData(rdata[0]),
        .MemReady(ready[0]), .Busy(busy[0]), .AdrErr(aerr[0])
    );

    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(0)) dut1 (
        .clk(clk), .rst(rst), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
        .Adr(adr[1]), .WriteData(wdata[1]), .ReadData(rdata[1]),
        .MemReady(ready[1]), .Busy(busy[1]), .AdrErr(aerr[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // One full request: drive, wait for MemReady, check, drop, update model.
    task automatic run_txn(input int d, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input string tag);
        bit illegal;
        int idx;
        int edges;
        bit busy_bad;
        logic [DW-1:0] exp_rd;
        illegal = (a[1:0] != 2'b00) || (32'(a[31:2]) >= DEPTH);
        idx     = int'(a[11:2]);
        if (illegal)      exp_rd = '0;
        else if (wr)      exp_rd = last_rd[d];
        else              exp_rd = model[d][idx];

        @(negedge clk);
        mem_read[d] = rd; mem_write[d] = wr; adr[d] = a; wdata[d] = wd;
        edges = 0; busy_bad = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (ready[d] !== 1'b1 && busy[d] !== 1'b1) busy_bad = 1;
        end while (ready[d] !== 1'b1 && edges < 20);

        checks++;
        if (ready[d] !== 1'b1 || edges != lat_of(d) + 1) begin
            errors++;
            $display("FAIL %s latency dut%0d: got %0d edges ready=%b, want %0d", tag, d, edges, ready[d], lat_of(d) + 1);
        end
        checks++;
        if (busy_bad || busy[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy dut%0d: waitgap=%0d busy_at_done=%b, want 0/0", tag, d, busy_bad, busy[d]);
        end
        checks++;
        if (aerr[d] !== illegal) begin
            errors++;
            $display("FAIL %s adrerr dut%0d: got %b want %b", tag, d, aerr[d], illegal);
        end
        checks++;
        if (rdata[d] !== exp_rd) begin
            errors++;
            $display("FAIL %s readdata dut%0d: got %h want %h", tag, d, rdata[d], exp_rd);
        end

        @(negedge clk);
        mem_read[d] = 1'b0; mem_write[d] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready[d] !== 1'b0 || aerr[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse dut%0d: ready=%b adrerr=%b, want 0/0", tag, d, ready[d], aerr[d]);
        end

        if (!illegal && wr) model[d][idx] = wd;
        last_rd[d] = exp_rd;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mem_read[d] = 1'b0; mem_write[d] = 1'b0; adr[d] = '0; wdata[d] = '0;
            last_rd[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdata[d] !== '0 || ready[d] !== 1'b0 || busy[d] !== 1'b0 || aerr[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: rd=%h ready=%b busy=%b adrerr=%b, want all 0", d, rdata[d], ready[d], busy[d], aerr[d]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        run_txn(0, 0, 1, 32'h10, 32'hDEADBEEF, "wr10");
        run_txn(0, 1, 0, 32'h10, 32'h0, "rd10");
        run_txn(1, 0, 1, 32'h0, 32'h12345678, "l0_wr0");
        run_txn(1, 1, 0, 32'h0, 32'h0, "l0_rd0");
        run_txn(0, 1, 0, 32'h13, 32'h0, "misaligned");
        run_txn(0, 1, 0, 32'h10, 32'h0, "rd10_again");
        run_txn(0, 0, 1, 32'h0, 32'h01020304, "wr0");
        run_txn(0, 0, 1, 32'hFFC, 32'hCAFEF00D, "wrffc");
        run_txn(0, 0, 1, 32'h1000, 32'hBAD0BAD0, "oor_wr");
        run_txn(0, 1, 0, 32'h0, 32'h0, "rd0_after_oor");
        run_txn(0, 1, 0, 32'hFFC, 32'h0, "rdffc_after_oor");
        run_txn(0, 1, 1, 32'h20, 32'hA5A5A5A5, "both_high");
        run_txn(0, 1, 0, 32'h20, 32'h0, "rd20");
        run_txn(1, 1, 1, 32'h20, 32'h5A5A5A5A, "l0_both_high");
        run_txn(1, 1, 0, 32'h20, 32'h0, "l0_rd20");
    endtask

    // Reset during WAIT abandons the write.
    task automatic test_reset_mid();
        run_txn(0, 0, 1, 32'h40, 32'h11111111, "pre40");
        @(negedge clk);
        mem_write[0] = 1'b1; adr[0] = 32'h40; wdata[0] = 32'h22222222;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; mem_write[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready[0] !== 1'b0 || busy[0] !== 1'b0 || rdata[0] !== '0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b busy=%b rd=%h, want 0/0/0", ready[0], busy[0], rdata[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        last_rd[0] = '0; last_rd[1] = '0;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_noready: ready=%b want 0", ready[0]);
            end
        end
        run_txn(0, 1, 0, 32'h40, 32'h0, "rd40_after_reset");
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 2; d++) begin
            run_txn(d, 0, 1, 32'h80, 32'h0BADCAFE, "b2b_wr");
            run_txn(d, 1, 0, 32'h80, 32'h0, "b2b_rd");
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int kind, op, word;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) begin
                run_txn(d, 0, 1, AW'(w * 4), $urandom, "rnd_init");
            end
            for (int n = 0; n < 30; n++) begin
                kind = $urandom_range(0, 9);
                op   = $urandom_range(0, 3);
                word = $urandom_range(0, 15);
                wd   = $urandom;
                if (kind == 0)      a = AW'(word * 4 + $urandom_range(1, 3));
                else if (kind == 1) a = AW'(32'h1000 + word * 4 + ($urandom_range(0, 7) << 12));
                else                a = AW'(word * 4);
                case (op)
                    0, 3:    run_txn(d, 1, 0, a, wd, "rnd_rd");
                    1:       run_txn(d, 0, 1, a, wd, "rnd_wr");
                    default: run_txn(d, 1, 1, a, wd, "rnd_both");
                endcase
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
